// File: rtl/cordic16_seq.sv
// cordic16_seq: drives one CORDIC sin/cos iteration run per request and holds the result on a valid/ready port.
// Optional CORDIC_SEQ_BACK2BACK_EN lets a request accepted during the result handshake go straight to LOAD.
module cordic16_seq #(
  parameter int W = 16,
  parameter int ITER = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  output logic         busy,
  output logic         load,
  output logic [3:0]   addr,
  output logic [W-1:0] endangle,
  input  logic [W-1:0] sin_in,
  input  logic [W-1:0] cos_in,
  output logic [W-1:0] sin_out,
  output logic [W-1:0] cos_out,
  output logic         valid,
  input  logic         ready
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_CAPT, S_DONE} state_t;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  state_t state, nxt;
  logic accept;
  always_comb begin
    accept = state == S_IDLE && start;
`ifdef CORDIC_SEQ_BACK2BACK_EN
    accept = accept || (state == S_DONE && valid && ready && start);
`endif
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_ITER;
      S_ITER:  nxt = addr == LAST ? S_CAPT : S_ITER;
      S_CAPT:  nxt = S_DONE;
      S_DONE:  nxt = valid && ready ? (accept ? S_LOAD : S_IDLE) : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clock)
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      load     <= 1'b0;
      valid    <= 1'b0;
      addr     <= '0;
      endangle <= '0;
      sin_out  <= '0;
      cos_out  <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt != S_IDLE;
      load  <= nxt == S_LOAD;
      valid <= nxt == S_DONE;
      addr  <= state == S_ITER && nxt == S_ITER ? addr + 4'd1 :
               (nxt == S_IDLE || nxt == S_LOAD) ? 4'd0 : addr;
      if (accept) endangle <= angle_in;
      if (state == S_CAPT) begin
        sin_out <= sin_in;
        cos_out <= cos_in;
      end
    end
endmodule

// File: doc/cordic16_seq.md
# cordic16_seq

Sequencer that sits directly upstream of the 16-bit CORDIC sin/cos core and also collects its result. Accepts an angle request, drives the core's `load`, `addr` and `endangle` inputs through one full iteration run, captures the final `sin`/`cos`, and presents them on a valid/ready output handshake. One request is in flight at a time.

## Interface
Parameters:
- `W`, 16: angle and result width.
- `ITER`, 16: iterations per run, legal range 1..16; `addr` stays 4 bits.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request strobe, sampled only when accepted (see Operation).
- `angle_in`, in, W: requested angle, latched on accept.
- `busy`, out, 1: high whenever state is not IDLE.
- `load`, out, 1: to core `load`; one-cycle pulse per run.
- `addr`, out, 4: to core `addr` (ROM index and iteration step).
- `endangle`, out, W: to core `endangle`; holds the latched request angle.
- `sin_in`, `cos_in`, in, W: from core `sin`/`cos`.
- `sin_out`, `cos_out`, out, W: captured result.
- `valid`, out, 1: result available.
- `ready`, in, 1: consumer accepts the result.

## Operation
- States: IDLE, LOAD, ITER, CAPT, DONE.
- IDLE: `load`=0, `addr`=0. On `start`=1, latch `angle_in` into `endangle` and go to LOAD.
- LOAD: `load`=1, `addr`=0. Always lasts one cycle, then goes to ITER with the counter at 0.
- ITER: `load`=0. `addr` = counter, which increments once per cycle from 0 to ITER-1. After the cycle with `addr`=ITER-1, go to CAPT.
- CAPT: `addr` holds ITER-1. At the end of this cycle, register `sin_in`/`cos_in` into `sin_out`/`cos_out`, set `valid`=1, and go to DONE.
- DONE: `valid`=1. `sin_out`/`cos_out` are stable until the next capture. On `valid && ready`, clear `valid` and go to IDLE.
- `start` is ignored in LOAD, ITER, CAPT and DONE (except as allowed by the Configuration macro). There is no queueing.
- `endangle` changes only on accept. Changes on `angle_in` after accept have no effect.
- `sin_out`/`cos_out` are copied bit-exact. The block does no arithmetic on the result.
- Reset values: state IDLE; `busy`, `load`, `valid` = 0; `addr`, `endangle`, `sin_out`, `cos_out` = 0.
- Reset in any state, including mid-ITER or in DONE with `ready` low, returns to IDLE next cycle with all reset values. Any in-flight result is discarded.
- `reset` and `start` high in the same cycle: reset wins and the request is not accepted.

## Timing
- Accept edge = E0, the edge at which `start` is sampled in IDLE.
- LOAD is cycle 1. ITER covers cycles 2..ITER+1. CAPT is cycle ITER+2.
- `valid` rises in cycle ITER+3, which is 19 for ITER=16.
- Fastest run without the macro: ITER+4 cycles from one accept to the next. DONE is held one cycle with `ready`=1, then IDLE takes one cycle to accept.
- `ready` is a pure input. `valid` does not depend combinationally on `ready`.
- All outputs are registered.

## Configuration
- `CORDIC_SEQ_BACK2BACK_EN` defined:
  - In DONE, if `valid && ready && start` are all high, latch `angle_in` and go directly to LOAD, skipping IDLE.
  - Throughput becomes one result per ITER+3 cycles.
  - `busy` stays high across the transition.
- Not defined:
  - DONE always returns to IDLE.
  - `start` in DONE is ignored.

## Test plan
- Basic run, ITER=16, behavioural core model: `start` with `angle_in`=0x2000 at E0.
  - `load`=1 in cycle 1 only.
  - `addr` = 0,1,…,15 in cycles 2..17.
  - `valid`=1 in cycle 19, with `sin_out`/`cos_out` equal to the model output for 0x2000.
- Backpressure: hold `ready`=0 for 5 cycles after `valid` rises, with `sin_in`/`cos_in` wiggling.
  - `valid` and outputs stay constant.
  - Raise `ready`: `valid`=0 and `busy`=0 next cycle.
- Start while busy: pulse `start` with `angle_in`=0x1234 during ITER at `addr`=5.
  - `endangle` stays 0x2000.
  - No extra `load` pulse.
  - Exactly one result.
- Reset mid-operation: assert `reset` at `addr`=7, together with `start`.
  - Next cycle all outputs are at reset values and state is IDLE.
  - The following `start` runs normally.
- Back-to-back, macro defined: `start`=1 with `angle_in`=0x4000 while `valid && ready`.
  - LOAD follows immediately.
  - Second `valid` arrives exactly 19 cycles after the first handshake edge.
  - Same stimulus without the macro: no LOAD until after IDLE.
- Parameter ITER=4: `addr` = 0..3, `valid` in cycle 7.
